// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte-stream and command-handshake bundle for the UART command controller.
// master = the controller (drives the command side), slave = byte source plus consumer.
interface uart_rx_cmd_ctrl_if #(
    parameter int p_ERR_W = 8
);
    logic               i_RX_DATA_VALID;
    logic [7:0]         i_DATA_RX;
    logic               o_PKT_VALID;
    logic               i_PKT_READY;
    logic [7:0]         o_CMD;
    logic [15:0]        o_ARG;
    logic               o_CHK_ERR;
    logic               o_TIMEOUT;
    logic               o_OVERRUN;
    logic [p_ERR_W-1:0] o_ERR_COUNT;

    modport master (
        input  i_RX_DATA_VALID,
        input  i_DATA_RX,
        input  i_PKT_READY,
        output o_PKT_VALID,
        output o_CMD,
        output o_ARG,
        output o_CHK_ERR,
        output o_TIMEOUT,
        output o_OVERRUN,
        output o_ERR_COUNT
    );

    modport slave (
        output i_RX_DATA_VALID,
        output i_DATA_RX,
        output i_PKT_READY,
        input  o_PKT_VALID,
        input  o_CMD,
        input  o_ARG,
        input  o_CHK_ERR,
        input  o_TIMEOUT,
        input  o_OVERRUN,
        input  o_ERR_COUNT
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Frames UART bytes into SYNC/CMD/ARG_HI/ARG_LO/CHK commands with timeout, checksum,
// a one-deep valid/ready output slot and a saturating error counter.
module uart_rx_cmd_ctrl #(
    parameter logic [7:0] p_SYNC_BYTE      = 8'hA5,
    parameter int         c_TIMEOUT_CYCLES = 8680,
    parameter int         p_TMO_W          = 16,
    parameter int         p_ERR_W          = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET_n,
    uart_rx_cmd_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        s_HUNT,
        s_CMD,
        s_ARG_HI,
        s_ARG_LO,
        s_CHK
    } state_t;

    localparam logic [p_TMO_W-1:0] c_TMO_LAST = p_TMO_W'(c_TIMEOUT_CYCLES - 1);

    state_t               state_q,     state_d;
    logic [p_TMO_W-1:0]   tmo_q,       tmo_d;
    logic [7:0]           cmd_sh_q,    cmd_sh_d;
    logic [7:0]           hi_sh_q,     hi_sh_d;
    logic [7:0]           lo_sh_q,     lo_sh_d;
    logic [7:0]           sum_q,       sum_d;
    logic                 pkt_valid_q, pkt_valid_d;
    logic [7:0]           cmd_q,       cmd_d;
    logic [15:0]          arg_q,       arg_d;
    logic                 chk_err_q,   chk_err_d;
    logic                 timeout_q,   timeout_d;
    logic                 overrun_q,   overrun_d;
    logic [p_ERR_W-1:0]   err_count_q, err_count_d;

    logic       byte_v;
    logic [7:0] din;
    logic       expired;
    logic       slot_free;

    always_comb begin
        byte_v    = bus.i_RX_DATA_VALID;
        din       = bus.i_DATA_RX;
        expired   = (tmo_q == c_TMO_LAST);
        slot_free = !pkt_valid_q || bus.i_PKT_READY;

        state_d     = state_q;
        tmo_d       = tmo_q;
        cmd_sh_d    = cmd_sh_q;
        hi_sh_d     = hi_sh_q;
        lo_sh_d     = lo_sh_q;
        sum_d       = sum_q;
        pkt_valid_d = pkt_valid_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        chk_err_d   = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;
        err_count_d = err_count_q;

        if (pkt_valid_q && bus.i_PKT_READY) begin
            pkt_valid_d = 1'b0;
        end

        if (state_q != s_HUNT) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            s_HUNT: begin
                if (byte_v && din == p_SYNC_BYTE) begin
                    state_d = s_CMD;
                    tmo_d   = '0;
                end
            end
            s_CMD: begin
                if (byte_v) begin
                    cmd_sh_d = din;
                    sum_d    = din;
                    tmo_d    = '0;
                    state_d  = s_ARG_HI;
                end
            end
            s_ARG_HI: begin
                if (byte_v) begin
                    hi_sh_d = din;
                    sum_d   = sum_q ^ din;
                    tmo_d   = '0;
                    state_d = s_ARG_LO;
                end
            end
            s_ARG_LO: begin
                if (byte_v) begin
                    lo_sh_d = din;
                    sum_d   = sum_q ^ din;
                    tmo_d   = '0;
                    state_d = s_CHK;
                end
            end
            s_CHK: begin
                if (byte_v) begin
                    tmo_d   = '0;
                    state_d = s_HUNT;
                    if (din != sum_q) begin
                        chk_err_d = 1'b1;
                    end else if (slot_free) begin
                        // A slot being drained this cycle can be refilled without a bubble.
                        pkt_valid_d = 1'b1;
                        cmd_d       = cmd_sh_q;
                        arg_d       = {hi_sh_q, lo_sh_q};
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = s_HUNT;
            end
        endcase

        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (state_q != s_HUNT && !byte_v && expired) begin
            state_d   = s_HUNT;
            tmo_d     = '0;
            timeout_d = 1'b1;
        end

        if ((chk_err_d || timeout_d || overrun_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET_n) begin
            state_q     <= s_HUNT;
            tmo_q       <= '0;
            cmd_sh_q    <= '0;
            hi_sh_q     <= '0;
            lo_sh_q     <= '0;
            sum_q       <= '0;
            pkt_valid_q <= 1'b0;
            cmd_q       <= '0;
            arg_q       <= '0;
            chk_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cmd_sh_q    <= cmd_sh_d;
            hi_sh_q     <= hi_sh_d;
            lo_sh_q     <= lo_sh_d;
            sum_q       <= sum_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            chk_err_q   <= chk_err_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.o_PKT_VALID = pkt_valid_q;
    assign bus.o_CMD       = cmd_q;
    assign bus.o_ARG       = arg_q;
    assign bus.o_CHK_ERR   = chk_err_q;
    assign bus.o_TIMEOUT   = timeout_q;
    assign bus.o_OVERRUN   = overrun_q;
    assign bus.o_ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed table, hand-written corner sequences and random
// byte streams, all checked every cycle against a packet-level reference model.
module tb_uart_rx_cmd_ctrl;

    localparam int         C    = 8680;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cmd_ctrl_if #(.p_ERR_W(8)) bus ();

    uart_rx_cmd_ctrl #(
        .p_SYNC_BYTE      (SYNC),
        .c_TIMEOUT_CYCLES (C),
        .p_TMO_W          (16),
        .p_ERR_W          (8)
    ) dut (
        .i_CLK     (clk),
        .i_RESET_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: packet bytes in a queue, timeout as elapsed cycles since last byte.
    bit          m_valid;
    logic [7:0]  m_cmd;
    logic [15:0] m_arg;
    bit          m_chk, m_tmo, m_ovr;
    int          m_err;
    bit          in_pkt;
    logic [7:0]  pkt[$];
    longint      cyc  = 0;
    longint      last = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [35:0] dut_bundle();
        return {bus.o_PKT_VALID, bus.o_CMD, bus.o_ARG, bus.o_CHK_ERR, bus.o_TIMEOUT,
                bus.o_OVERRUN, bus.o_ERR_COUNT};
    endfunction

    task automatic model_step();
        bit         v;
        bit         free;
        logic [7:0] d;
        cyc++;
        v = bus.i_RX_DATA_VALID;
        d = bus.i_DATA_RX;
        if (!rst_n) begin
            m_valid = 0; m_cmd = '0; m_arg = '0;
            m_chk = 0; m_tmo = 0; m_ovr = 0; m_err = 0;
            in_pkt = 0; pkt.delete();
            return;
        end
        m_chk = 0; m_tmo = 0; m_ovr = 0;
        free = !m_valid || bus.i_PKT_READY;
        if (m_valid && bus.i_PKT_READY) m_valid = 0;
        if (!in_pkt) begin
            if (v && d == SYNC) begin
                in_pkt = 1; pkt.delete(); last = cyc;
            end
        end else if (v) begin
            pkt.push_back(d);
            last = cyc;
            if (pkt.size() == 4) begin
                in_pkt = 0;
                if ((pkt[0] ^ pkt[1] ^ pkt[2]) == pkt[3]) begin
                    if (free) begin
                        m_valid = 1; m_cmd = pkt[0]; m_arg = {pkt[1], pkt[2]};
                    end else begin
                        m_ovr = 1;
                    end
                end else begin
                    m_chk = 1;
                end
            end
        end else if (cyc - last >= C) begin
            in_pkt = 0; m_tmo = 1;
        end
        if ((m_chk || m_tmo || m_ovr) && m_err < 255) m_err++;
    endtask

    task automatic cycle();
        logic [35:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_valid, m_cmd, m_arg, m_chk, m_tmo, m_ovr, m_err[7:0]};
        check("model", 64'(dut_bundle()), 64'(exp));
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_DATA_VALID = 1'b1;
        bus.i_DATA_RX       = b;
        cycle();
        bus.i_RX_DATA_VALID = 1'b0;
        bus.i_DATA_RX       = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] k);
        send(SYNC); send(c); send(h); send(l); send(k);
    endtask

    typedef struct {
        logic [7:0]  b[7];
        int          n;
        bit          ready;
        bit          exp_valid;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_arg;
        logic [2:0]  exp_pulse;   // {chk_err, timeout, overrun}
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [35:0] exp;
        int          long_left;

        vt[0] = '{b: '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h36, 8'h00, 8'h00}, n: 5, ready: 1,
                  exp_valid: 1, exp_cmd: 8'h10, exp_arg: 16'h1234, exp_pulse: 3'b000, exp_err: 8'd0};
        vt[1] = '{b: '{8'hA5, 8'h10, 8'h12, 8'h34, 8'h37, 8'h00, 8'h00}, n: 5, ready: 1,
                  exp_valid: 0, exp_cmd: 8'h00, exp_arg: 16'h0000, exp_pulse: 3'b100, exp_err: 8'd1};
        vt[2] = '{b: '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'hA6}, n: 7, ready: 1,
                  exp_valid: 1, exp_cmd: 8'hA5, exp_arg: 16'h0102, exp_pulse: 3'b000, exp_err: 8'd0};
        vt[3] = '{b: '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h21, 8'h00, 8'h00}, n: 5, ready: 0,
                  exp_valid: 1, exp_cmd: 8'h20, exp_arg: 16'h0001, exp_pulse: 3'b000, exp_err: 8'd0};
        vt[4] = '{b: '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00}, n: 5, ready: 1,
                  exp_valid: 1, exp_cmd: 8'hA5, exp_arg: 16'hA5A5, exp_pulse: 3'b000, exp_err: 8'd0};
        vt[5] = '{b: '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00}, n: 5, ready: 0,
                  exp_valid: 0, exp_cmd: 8'h00, exp_arg: 16'h0000, exp_pulse: 3'b100, exp_err: 8'd1};

        bus.i_RX_DATA_VALID = 1'b0;
        bus.i_DATA_RX       = 8'h00;
        bus.i_PKT_READY     = 1'b0;

        do_reset();
        check("reset_state", 64'(dut_bundle()), 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.i_PKT_READY = vt[i].ready;
            for (int j = 0; j < vt[i].n; j++) send(vt[i].b[j]);
            exp = {vt[i].exp_valid, vt[i].exp_cmd, vt[i].exp_arg, vt[i].exp_pulse, vt[i].exp_err};
            check($sformatf("vec%0d", i), 64'(dut_bundle()), 64'(exp));
            $display("vec %0d: valid=%0b cmd=%h arg=%h err=%0d", i, bus.o_PKT_VALID, bus.o_CMD,
                     bus.o_ARG, bus.o_ERR_COUNT);
        end

        // Timeout fires exactly C cycles after the last byte.
        do_reset();
        bus.i_PKT_READY = 1'b1;
        send(SYNC); send(8'h10);
        idle(C - 1);
        check("tmo_early", 64'(bus.o_TIMEOUT), 64'd0);
        cycle();
        check("tmo_pulse", 64'({bus.o_TIMEOUT, bus.o_ERR_COUNT}), 64'({1'b1, 8'd1}));
        send_pkt(8'h20, 8'h00, 8'h01, 8'h21);
        check("tmo_recover", 64'({bus.o_PKT_VALID, bus.o_CMD, bus.o_ARG}), 64'({1'b1, 8'h20, 16'h0001}));
        $display("timeout sequence: err=%0d", bus.o_ERR_COUNT);

        // A byte on the expiry cycle keeps the packet alive.
        do_reset();
        send(SYNC); send(8'h10);
        idle(C - 1);
        send(8'h12);
        check("tmo_byte_wins", 64'(bus.o_TIMEOUT), 64'd0);
        send(8'h34); send(8'h36);
        check("tmo_byte_pkt", 64'({bus.o_PKT_VALID, bus.o_CMD, bus.o_ARG, bus.o_ERR_COUNT}),
              64'({1'b1, 8'h10, 16'h1234, 8'd0}));
        $display("byte-wins sequence: cmd=%h arg=%h", bus.o_CMD, bus.o_ARG);

        // Overrun with a full slot, then acceptance.
        do_reset();
        bus.i_PKT_READY = 1'b0;
        send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
        send_pkt(8'h20, 8'h00, 8'h01, 8'h21);
        check("ovr_pulse", 64'(dut_bundle()), 64'({1'b1, 8'h10, 16'h1234, 3'b001, 8'd1}));
        idle(3);
        check("ovr_hold", 64'({bus.o_PKT_VALID, bus.o_CMD, bus.o_ARG}), 64'({1'b1, 8'h10, 16'h1234}));
        bus.i_PKT_READY = 1'b1;
        cycle();
        check("ovr_accept", 64'(bus.o_PKT_VALID), 64'd0);
        $display("overrun sequence: err=%0d", bus.o_ERR_COUNT);

        // Slot drained on the same cycle a new command arrives: no overrun.
        do_reset();
        bus.i_PKT_READY = 1'b0;
        send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
        send(SYNC); send(8'h20); send(8'h00); send(8'h01);
        bus.i_PKT_READY = 1'b1;
        send(8'h21);
        check("same_cycle_reload", 64'(dut_bundle()), 64'({1'b1, 8'h20, 16'h0001, 3'b000, 8'd0}));
        $display("same-cycle reload: cmd=%h", bus.o_CMD);

        // Reset mid-packet, with a command held in the slot.
        bus.i_PKT_READY = 1'b0;
        send(SYNC); send(8'h10); send(8'h12);
        do_reset();
        check("mid_reset", 64'(dut_bundle()), 64'd0);
        bus.i_PKT_READY = 1'b1;
        send_pkt(8'h33, 8'h44, 8'h55, 8'h33 ^ 8'h44 ^ 8'h55);
        check("post_reset_pkt", 64'({bus.o_PKT_VALID, bus.o_CMD, bus.o_ARG}), 64'({1'b1, 8'h33, 16'h4455}));
        $display("mid-packet reset: cmd=%h arg=%h", bus.o_CMD, bus.o_ARG);

        // Error counter saturation.
        do_reset();
        repeat (260) send_pkt(8'h00, 8'h00, 8'h00, 8'h01);
        check("err_saturate", 64'(bus.o_ERR_COUNT), 64'hFF);
        $display("saturation: err=%0d", bus.o_ERR_COUNT);

        // Random byte streams against the model.
        do_reset();
        long_left = 3;
        for (int p = 0; p < 400; p++) begin
            logic [7:0] c, h, l, k, raw[5];
            int         nb;
            c = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            k = c ^ h ^ l;
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            raw[0] = SYNC; raw[1] = c; raw[2] = h; raw[3] = l; raw[4] = k;
            nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 5;
            repeat ($urandom_range(0, 2)) begin
                bus.i_PKT_READY = ($urandom_range(0, 3) != 0);
                send(8'($urandom));
            end
            for (int j = 0; j < nb; j++) begin
                bus.i_PKT_READY = ($urandom_range(0, 3) != 0);
                send(raw[j]);
                if (long_left > 0 && $urandom_range(0, 99) == 0) begin
                    long_left--;
                    idle(C - 1 + $urandom_range(0, 1));
                end else begin
                    idle($urandom_range(0, 2));
                end
            end
            $display("rand pkt %0d: bytes=%0d cmd=%h arg=%h%h chk=%h err=%0d", p, nb, c, h, l, k,
                     bus.o_ERR_COUNT);
        end
        idle(C + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
